// File: rtl/acum_pkg.sv
// Shared definitions for the accumulator write-back stage: control-bit
// positions, accumulator select codes and the default data width.
package acum_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int CTL_W      = 3;

    // Bit positions inside the 3-bit accumulator control field
    localparam int CTL_WE  = 0;
    localparam int CTL_SEL = 1;
    localparam int CTL_FLG = 2;

    // Accumulator select codes carried in ctrl[CTL_SEL]
    localparam logic ACUM_A = 1'b0;
    localparam logic ACUM_B = 1'b1;

endpackage

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register. Flush beats stall beats normal capture; both
// flush and stall turn the entry into a bubble while holding data/ctrl.
module wb_pipe_reg
    import acum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTL_W-1:0]  ctrl_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTL_W-1:0]  ctrl_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTL_W-1:0]  ctrl_q,  ctrl_d;

    // Next entry: bubble on flush or stall, otherwise take the memory stage
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (stall_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_i;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    // Register update with synchronous clear
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/wb_acum.sv
// Write-back stage: commits the MEM/WB entry to accumulators A/B and the
// Z/N flags, forwards the pending write to execute, counts retirements.
module wb_acum
    import acum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] iDataToWB,
    input  logic [CTL_W-1:0]  iControlAcum_MEM,
    input  logic              iValid_MEM,
    input  logic              iStall,
    input  logic              iFlush,
    output logic [DATA_W-1:0] oAcumA,
    output logic [DATA_W-1:0] oAcumB,
    output logic              oZero,
    output logic              oNeg,
    output logic              oFwdValid,
    output logic              oFwdSel,
    output logic [DATA_W-1:0] oFwdData,
    output logic [CNT_W-1:0]  oRetired
);

    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [CTL_W-1:0]  wb_ctrl;

    logic [DATA_W-1:0] acum_a_q, acum_a_d;
    logic [DATA_W-1:0] acum_b_q, acum_b_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    wb_pipe_reg #(
        .DATA_W (DATA_W)
    ) u_pipe (
        .clk_i   (Clock),
        .srst_i  (Reset),
        .valid_i (iValid_MEM),
        .data_i  (iDataToWB),
        .ctrl_i  (iControlAcum_MEM),
        .stall_i (iStall),
        .flush_i (iFlush),
        .valid_o (wb_valid),
        .data_o  (wb_data),
        .ctrl_o  (wb_ctrl)
    );

    // Commit the current entry; the register's own update on the same edge
    // is independent, so consecutive writes retire in program order
    always_comb begin
        acum_a_d  = acum_a_q;
        acum_b_d  = acum_b_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        retired_d = retired_q;
        if (wb_valid) begin
            if (wb_ctrl[CTL_WE]) begin
                if (wb_ctrl[CTL_SEL] == ACUM_A) begin
                    acum_a_d = wb_data;
                end else begin
                    acum_b_d = wb_data;
                end
            end
            // Flags may be refreshed without an accumulator write
            if (wb_ctrl[CTL_FLG]) begin
                zero_d = (wb_data == '0);
                neg_d  = wb_data[DATA_W-1];
            end
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Architectural state; reset drops any pending entry uncommitted
    always_ff @(posedge Clock) begin
        if (Reset) begin
            acum_a_q  <= '0;
            acum_b_q  <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            acum_a_q  <= acum_a_d;
            acum_b_q  <= acum_b_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
            retired_q <= retired_d;
        end
    end

    assign oAcumA    = acum_a_q;
    assign oAcumB    = acum_b_q;
    assign oZero     = zero_q;
    assign oNeg      = neg_q;
    assign oRetired  = retired_q;

    assign oFwdValid = wb_valid & wb_ctrl[CTL_WE];
    assign oFwdSel   = wb_ctrl[CTL_SEL];
    assign oFwdData  = wb_data;

endmodule

// File: doc/wb_acum.md
Name: wb_acum

Overview:
- Write-back stage of the 8-bit accumulator pipeline, directly downstream of the memory stage.
- Registers the memory stage's result (data plus 3-bit accumulator control) in a MEM/WB pipeline register, then commits it one edge later to architectural accumulators A and B and the Z/N flags.
- Drives a forwarding bus so the execute stage can bypass a pending write.
- Counts retired instructions.

Parameters:
- DATA_W, 8, accumulator and data width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- iDataToWB  in  DATA_W  result from memory stage (ALU or RAM value).
- iControlAcum_MEM  in  3  accumulator control from memory stage.
- iValid_MEM  in  1  memory stage holds a real instruction.
- iStall  in  1  pipeline stall; do not capture new input.
- iFlush  in  1  insert bubble into the MEM/WB register.
- oAcumA  out  DATA_W  architectural accumulator A.
- oAcumB  out  DATA_W  architectural accumulator B.
- oZero  out  1  zero flag.
- oNeg  out  1  negative flag.
- oFwdValid  out  1  pending write in MEM/WB register.
- oFwdSel  out  1  target of the pending write: 0=A, 1=B.
- oFwdData  out  DATA_W  data of the pending write.
- oRetired  out  CNT_W  count of committed valid instructions.

Behaviour:
- Control encoding, iControlAcum_MEM:
  - [0] write enable.
  - [1] target: 0=A, 1=B.
  - [2] update Z/N flags.
- Reset (synchronous, Reset=1 at a rising edge):
  - All outputs go to 0: oAcumA, oAcumB, oZero, oNeg, oRetired.
  - MEM/WB register cleared: valid=0, data=0, ctrl=0, so oFwdValid=0, oFwdSel=0, oFwdData=0.
  - Reset has priority over flush, stall and commit. A reset mid-operation discards the pending entry without committing it.
- Pipeline register (per edge, Reset=0). Priority order:
  - iFlush=1: valid<=0, data/ctrl don't-care (held).
  - else iStall=1: valid<=0, data/ctrl held. The entry is consumed by this edge's commit; upstream holds its own data.
  - else: valid<=iValid_MEM, data<=iDataToWB, ctrl<=iControlAcum_MEM.
- Commit (same edge, uses the current register contents before update). Only when valid=1:
  - If ctrl[0]=1: write data into A or B according to ctrl[1].
  - If ctrl[2]=1: oZero<=(data==0) and oNeg<=data[DATA_W-1]. Flags update even when ctrl[0]=0.
  - oRetired increments by 1, wrapping from all-ones to 0.
  - Bubbles (valid=0) change nothing.
- Latency: a value presented at MEM before edge N appears on oFwdData after edge N and on oAcumA/B after edge N+1.
- Forwarding is combinational from the register:
  - oFwdValid = valid & ctrl[0].
  - oFwdSel = ctrl[1].
  - oFwdData = data.
- Commit and capture on the same edge are independent: back-to-back writes to the same accumulator commit in program order.
- Flush and commit on the same edge: the current entry still commits; only the incoming entry is dropped.

Decomposition:
- Shared package acum_pkg:
  - control-bit indices: CTL_WE=0, CTL_SEL=1, CTL_FLG=2.
  - ACUM_A=0, ACUM_B=1.
  - DATA_W default.
- Sub-module wb_pipe_reg: MEM/WB register with flush/stall priority. The accumulator, flag and counter logic stays in wb_acum.

Test Plan:
- Reset: hold Reset=1 for 2 edges with random inputs -> all outputs 0 and oFwdValid=0. Release Reset -> nothing changes until a valid entry is presented.
- Basic write: data 0x5A, ctrl 3'b001, valid -> after edge 1, oFwdValid=1, oFwdSel=0, oFwdData=0x5A. After edge 2, oAcumA=0x5A, oAcumB=0, oRetired=1.
- Flags: data 0x80, ctrl 3'b111 -> after edge 2, oAcumB=0x80, oNeg=1, oZero=0. Then data 0x00, ctrl 3'b100 -> oZero=1, oNeg=0, accumulators unchanged, oRetired=2.
- Back-to-back: writes 0x11 then 0x22 to A on consecutive cycles -> oAcumA=0x11 after edge 2 and 0x22 after edge 3. oFwdData tracks 0x11 then 0x22.
- Stall/flush: pending entry 0x33→A, assert iStall with 0x44 at the input -> 0x33 commits once, oFwdValid=0, 0x44 is not captured. Flush with a valid input -> the bubble adds no retire and makes no write.
- Wrap and reset mid-op: preset 65535 retires, then one more -> oRetired=0. Pending write to A with Reset asserted on the same edge -> oAcumA stays 0.
